// File: rtl/cc_mem_write_buffer.sv
// Two-entry store buffer between the datapath and main memory.
// Drains entries through a WE/ACK handshake and flags reads that hit pending stores.
module cc_mem_write_buffer #(
    parameter int unsigned DATAWIDTH_BUS  = 32,
    parameter int unsigned DATAWIDTH_ADDR = 16
) (
    input  logic                      CC_MEM_WRITE_CLOCK_50,
    input  logic                      CC_MEM_WRITE_RESET_InLow,
    input  logic                      CC_MEM_WRITE_WR,
    input  logic [DATAWIDTH_ADDR-1:0] CC_MEM_WRITE_InADDR,
    input  logic [DATAWIDTH_BUS-1:0]  CC_MEM_WRITE_InBUS,
    input  logic [DATAWIDTH_ADDR-1:0] CC_MEM_WRITE_RDADDR,
    input  logic                      CC_MEM_WRITE_MemACK,
    output logic                      CC_MEM_WRITE_MemWE,
    output logic [DATAWIDTH_ADDR-1:0] CC_MEM_WRITE_MemADDR,
    output logic [DATAWIDTH_BUS-1:0]  CC_MEM_WRITE_MemDATA,
    output logic                      CC_MEM_WRITE_FULL,
    output logic                      CC_MEM_WRITE_EMPTY,
    output logic                      CC_MEM_WRITE_HIT
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [1:0]                count_q;
    logic                      wr_ptr_q, rd_ptr_q;
    logic [DATAWIDTH_ADDR-1:0] addr_q [2];
    logic [DATAWIDTH_BUS-1:0]  data_q [2];
    logic                      mem_we_q;
    logic [DATAWIDTH_ADDR-1:0] mem_addr_q;
    logic [DATAWIDTH_BUS-1:0]  mem_data_q;

    logic push, pop, load;

    // A push is refused whenever the buffer is full, even if this edge also pops.
    assign push = CC_MEM_WRITE_WR && (count_q != 2'd2);
    assign pop  = (state_q == ST_WRITE) && CC_MEM_WRITE_MemACK;
    assign load = (state_q == ST_IDLE) && (count_q != 2'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (load) state_d = ST_WRITE;
            ST_WRITE:   if (pop) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CC_MEM_WRITE_CLOCK_50 or negedge CC_MEM_WRITE_RESET_InLow) begin
        if (!CC_MEM_WRITE_RESET_InLow) begin
            state_q    <= ST_IDLE;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            addr_q[0]  <= '0;
            addr_q[1]  <= '0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                addr_q[wr_ptr_q] <= CC_MEM_WRITE_InADDR;
                data_q[wr_ptr_q] <= CC_MEM_WRITE_InBUS;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                mem_we_q <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 2'd1;
            end
            if (load) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= addr_q[rd_ptr_q];
                mem_data_q <= data_q[rd_ptr_q];
            end
        end
    end

    // The head entry stays valid while it is being written, so it still counts for hazards.
    always_comb begin
        CC_MEM_WRITE_HIT = 1'b0;
        if (count_q != 2'd0 && addr_q[rd_ptr_q] == CC_MEM_WRITE_RDADDR) begin
            CC_MEM_WRITE_HIT = 1'b1;
        end
        if (count_q == 2'd2 && addr_q[~rd_ptr_q] == CC_MEM_WRITE_RDADDR) begin
            CC_MEM_WRITE_HIT = 1'b1;
        end
    end

    assign CC_MEM_WRITE_MemWE   = mem_we_q;
    assign CC_MEM_WRITE_MemADDR = mem_addr_q;
    assign CC_MEM_WRITE_MemDATA = mem_data_q;
    assign CC_MEM_WRITE_FULL    = (count_q == 2'd2);
    assign CC_MEM_WRITE_EMPTY   = (count_q == 2'd0);

endmodule

// File: tb/tb_cc_mem_write_buffer.sv
// Bench for cc_mem_write_buffer: directed scenarios then random traffic, checked against
// a queue-based model of pending stores and the memory-side handshake.
module tb_cc_mem_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr;
    logic [15:0] in_addr;
    logic [31:0] in_bus;
    logic [15:0] rdaddr;
    logic        mem_ack;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        full, empty, hit;

    always #5 clk = ~clk;

    cc_mem_write_buffer #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR(16)) dut (
        .CC_MEM_WRITE_CLOCK_50   (clk),
        .CC_MEM_WRITE_RESET_InLow(rst_n),
        .CC_MEM_WRITE_WR         (wr),
        .CC_MEM_WRITE_InADDR     (in_addr),
        .CC_MEM_WRITE_InBUS      (in_bus),
        .CC_MEM_WRITE_RDADDR     (rdaddr),
        .CC_MEM_WRITE_MemACK     (mem_ack),
        .CC_MEM_WRITE_MemWE      (mem_we),
        .CC_MEM_WRITE_MemADDR    (mem_addr),
        .CC_MEM_WRITE_MemDATA    (mem_data),
        .CC_MEM_WRITE_FULL       (full),
        .CC_MEM_WRITE_EMPTY      (empty),
        .CC_MEM_WRITE_HIT        (hit)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } ent_t;

    // Model: pending stores in arrival order, plus memory-side handshake progress.
    ent_t        q[$];
    bit          in_flight;
    int          gap;
    logic [15:0] m_addr;
    logic [31:0] m_data;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic [15:0] ra);
        foreach (q[i]) if (q[i].a == ra) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".we"},    {63'd0, mem_we},   {63'd0, in_flight});
        check({tag, ".addr"},  {48'd0, mem_addr}, {48'd0, m_addr});
        check({tag, ".data"},  {32'd0, mem_data}, {32'd0, m_data});
        check({tag, ".full"},  {63'd0, full},     {63'd0, q.size() == 2});
        check({tag, ".empty"}, {63'd0, empty},    {63'd0, q.size() == 0});
        check({tag, ".hit"},   {63'd0, hit},      {63'd0, model_hit(rdaddr)});
    endtask

    task automatic model_reset();
        q.delete();
        in_flight = 1'b0;
        gap       = 0;
        m_addr    = '0;
        m_data    = '0;
    endtask

    task automatic step(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [15:0] ra, input logic ack);
        int  old_size;
        bit  do_push;
        wr = w; in_addr = a; in_bus = d; rdaddr = ra; mem_ack = ack;
        #1;
        check("pre.hit", {63'd0, hit}, {63'd0, model_hit(ra)});
        @(posedge clk);
        old_size = q.size();
        do_push  = w && old_size < 2;
        if (in_flight) begin
            if (ack) begin
                in_flight = 1'b0;
                void'(q.pop_front());
                gap = 1;
            end
        end else if (gap > 0) begin
            gap--;
        end else if (old_size > 0) begin
            in_flight = 1'b1;
            m_addr    = q[0].a;
            m_data    = q[0].d;
        end
        if (do_push) q.push_back('{a: a, d: d});
        #1;
        check_all("step");
    endtask

    initial begin
        logic        rw, rack;
        logic [15:0] ra, rra;
        logic [31:0] rd;

        model_reset();
        rst_n = 1'b0; wr = 1'b0; in_addr = '0; in_bus = '0; rdaddr = '0; mem_ack = 1'b0;
        #2;
        check_all("reset");
        for (int i = 0; i < 4; i++) begin
            wr = ~wr; in_addr = 16'h1234; in_bus = 32'hCAFEF00D; mem_ack = 1'b1;
            @(posedge clk); #1;
            check_all("reset.hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 16'h0, 32'h0, 16'h0, 1'b1);

        // Single store, ACK two cycles after WE rises.
        step(1, 16'h0010, 32'hDEADBEEF, 16'h0010, 0);
        check("single.empty", {63'd0, empty}, 64'd0);
        step(0, 16'h0, 32'h0, 16'h0010, 0);
        check("single.we", {63'd0, mem_we}, 64'd1);
        check("single.addr", {48'd0, mem_addr}, 64'h0010);
        check("single.data", {32'd0, mem_data}, 64'hDEADBEEF);
        step(0, 16'h0, 32'h0, 16'h0010, 0);
        step(0, 16'h0, 32'h0, 16'h0010, 1);
        check("single.popped", {63'd0, empty}, 64'd1);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 32'h0, 16'h0, 0);

        // Fill and overflow with ACK low; third store is dropped.
        step(1, 16'h0001, 32'h11111111, 16'h0003, 0);
        step(1, 16'h0002, 32'h22222222, 16'h0003, 0);
        check("fill.full", {63'd0, full}, 64'd1);
        step(1, 16'h0003, 32'h33333333, 16'h0003, 0);
        check("fill.drop.hit", {63'd0, hit}, 64'd0);
        for (int i = 0; i < 2; i++) step(0, 16'h0, 32'h0, 16'h0, 0);
        for (int i = 0; i < 10; i++) step(0, 16'h0, 32'h0, 16'h0002, 1);

        // Push coinciding with pop while one entry is in WRITE.
        step(1, 16'h0040, 32'h40404040, 16'h0, 0);
        step(0, 16'h0, 32'h0, 16'h0, 0);
        step(1, 16'h0041, 32'h41414141, 16'h0041, 1);
        check("pushpop.full", {63'd0, full}, 64'd0);
        for (int i = 0; i < 6; i++) step(0, 16'h0, 32'h0, 16'h0041, 1);

        // Hazard detection.
        step(1, 16'h00A0, 32'hA0A0A0A0, 16'h00A0, 0);
        step(0, 16'h0, 32'h0, 16'h00A1, 0);
        step(0, 16'h0, 32'h0, 16'h00A0, 0);
        step(0, 16'h0, 32'h0, 16'h00A0, 1);
        step(0, 16'h0, 32'h0, 16'h00A0, 0);

        // Reset while a write is outstanding and the buffer is full.
        step(1, 16'h0050, 32'h50505050, 16'h0, 0);
        step(1, 16'h0051, 32'h51515151, 16'h0, 0);
        step(0, 16'h0, 32'h0, 16'h0, 0);
        check("midrst.pre.we", {63'd0, mem_we}, 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 16'h0, 32'h0, 16'h0050, 1);

        // Random traffic over a small address space so hazards occur.
        for (int i = 0; i < 400; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 16'($urandom_range(0, 3));
            rd   = $urandom;
            rra  = 16'($urandom_range(0, 3));
            rack = 1'($urandom_range(0, 2) != 0);
            step(rw, ra, rd, rra, rack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
